// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: multi-cycle MIPS-subset control FSM with memory watchdog; `MULTICYCLE_CTRL_JAL_EN adds JAL
module multicycle_ctrl #(
  parameter int OP_W        = 6,
  parameter int ALU_OP_W    = 3,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [OP_W-1:0]     instr_op_i,
  input  logic                mem_ready_i,
  input  logic                zero_i,
  output logic                IRWrite_o,
  output logic                PCWrite_o,
  output logic                Jump_o,
  output logic                MemRead_o,
  output logic                MemWrite_o,
  output logic                MemtoReg_o,
  output logic                RegWrite_o,
  output logic                RegDst_o,
  output logic                ALUSrc_o,
  output logic                Branch_o,
  output logic                savePC_o,
  output logic [ALU_OP_W-1:0] ALU_op_o,
  output logic [2:0]          state_o,
  output logic                illegal_o,
  output logic                timeout_o
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
`ifdef MULTICYCLE_CTRL_JAL_EN
  localparam bit JAL_EN = 1'b1;
`else
  localparam bit JAL_EN = 1'b0;
`endif
  localparam logic [OP_W-1:0] OP_R    = OP_W'(6'h00);
  localparam logic [OP_W-1:0] OP_J    = OP_W'(6'h02);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(6'h03);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(6'h04);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'(6'h05);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'(6'h08);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'(6'h0D);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(6'h0F);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(6'h23);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(6'h2B);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3, WB = 3'd4, HALT = 3'd7} state_t;
  state_t state_q, state_d;
  logic [OP_W-1:0] op_q;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic to_q, waiting, hit, in_f, in_d, in_e, in_m, in_w, dec_j, dec_jal, legal, is_br, take_br, wb_jal, g;
  logic [ALU_OP_W-1:0] alu;
  always_comb begin
    in_f    = state_q == FETCH;
    in_d    = state_q == DECODE;
    in_e    = state_q == EXEC;
    in_m    = state_q == MEM;
    in_w    = state_q == WB;
    dec_j   = instr_op_i == OP_J;
    dec_jal = JAL_EN && instr_op_i == OP_JAL;
    legal   = dec_j || dec_jal || instr_op_i == OP_R || instr_op_i == OP_ADDI || instr_op_i == OP_BEQ ||
              instr_op_i == OP_BNE || instr_op_i == OP_ORI || instr_op_i == OP_LUI || instr_op_i == OP_LW ||
              instr_op_i == OP_SW;
    is_br   = op_q == OP_BEQ || op_q == OP_BNE;
    take_br = op_q == OP_BEQ ? zero_i : op_q == OP_BNE ? !zero_i : 1'b0;
    wb_jal  = in_w && JAL_EN && op_q == OP_JAL;
    alu     = op_q == OP_R   ? ALU_OP_W'(3'b010) :
              op_q == OP_BEQ ? ALU_OP_W'(3'b001) :
              op_q == OP_BNE ? ALU_OP_W'(3'b011) :
              op_q == OP_ORI ? ALU_OP_W'(3'b100) :
              op_q == OP_LUI ? ALU_OP_W'(3'b101) : ALU_OP_W'(3'b000);
    waiting = (in_f || in_m) && !mem_ready_i;
    cnt_inc = cnt_q + CW'(1);
    hit     = waiting && cnt_inc == CW'(MEM_TIMEOUT);
    // counter clears whenever the FSM is outside a wait, so entry to FETCH/MEM always starts at 0
    cnt_d   = state_q == HALT ? cnt_q : waiting ? cnt_inc : '0;
    state_d = FETCH;
    case (state_q)
      FETCH:   state_d = hit ? HALT : mem_ready_i ? DECODE : FETCH;
      DECODE:  state_d = (dec_j || !legal) ? FETCH : dec_jal ? WB : EXEC;
      EXEC:    state_d = is_br ? FETCH : (op_q == OP_LW || op_q == OP_SW) ? MEM : WB;
      MEM:     state_d = hit ? HALT : !mem_ready_i ? MEM : op_q == OP_LW ? WB : FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      to_q    <= to_q | hit;
      if (in_d) op_q <= instr_op_i;
    end
  end
  assign g          = !rst_i;
  assign IRWrite_o  = g && in_f && mem_ready_i;
  assign PCWrite_o  = g && ((in_f && mem_ready_i) || (in_d && dec_j) || (in_e && take_br) || wb_jal);
  assign Jump_o     = g && ((in_d && dec_j) || wb_jal);
  assign MemRead_o  = g && (in_f || (in_m && op_q == OP_LW));
  assign MemWrite_o = g && in_m && op_q == OP_SW;
  assign MemtoReg_o = g && in_w && op_q == OP_LW;
  assign RegWrite_o = g && in_w;
  assign RegDst_o   = g && in_w && op_q == OP_R;
  assign ALUSrc_o   = g && in_e && (op_q == OP_ADDI || op_q == OP_ORI || op_q == OP_LUI || op_q == OP_LW || op_q == OP_SW);
  assign Branch_o   = g && in_e && is_br;
  assign savePC_o   = g && wb_jal;
  assign ALU_op_o   = (g && in_e) ? alu : '0;
  assign state_o    = g ? state_q : 3'd0;
  assign illegal_o  = g && in_d && !legal;
  assign timeout_o  = g && to_q;
endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle main control unit for the MIPS-subset CPU; it replaces the single-cycle opcode decoder with a state machine that sequences each instruction through fetch, decode, execute, memory and write-back. It sits between the instruction register / memory interface and the datapath. It drives the datapath strobes per state and stalls on a memory ready handshake. A memory-timeout watchdog halts the machine. Opcode width and ALU-op width are parametrised.

## Interface
- OP_W, 6, opcode width
- ALU_OP_W, 3, ALU_op_o width; encodings below are zero-extended
- MEM_TIMEOUT, 15, max consecutive wait cycles with mem_ready_i low (≥1)

- clk_i  in  1  clock; all state changes on the rising edge
- rst_i  in  1  reset; synchronous, active-high
- instr_op_i  in  OP_W  opcode field from instruction register
- mem_ready_i  in  1  memory transfer complete this cycle
- zero_i  in  1  ALU zero flag (combinational, valid in EXEC)
- IRWrite_o, PCWrite_o, Jump_o  out  1  IR load, PC load, PC source = jump target
- MemRead_o, MemWrite_o, MemtoReg_o  out  1  memory strobes; write-back from memory
- RegWrite_o, RegDst_o, ALUSrc_o, Branch_o, savePC_o  out  1  datapath controls
- ALU_op_o  out  ALU_OP_W  ALU operation class
- state_o  out  3  current state code
- illegal_o  out  1  one-cycle pulse on an undecoded opcode
- timeout_o  out  1  sticky; memory watchdog fired

## Operation
- Opcodes: R 0x00 (ALU_op 010), ADDI 0x08 (000), BEQ 0x04 (001), BNE 0x05 (011), ORI 0x0D (100), LUI 0x0F (101), LW 0x23 (000), SW 0x2B (000), J 0x02.
- States and codes: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 7.
- Outputs are combinational from state and latched opcode op_q. Any output not listed for a state is 0.
- FETCH: MemRead_o=1. If mem_ready_i=1, then IRWrite_o=1 and PCWrite_o=1 (PC+4), and the next state is DECODE. Otherwise stay in FETCH.
- DECODE: op_q <= instr_op_i.
  - J: Jump_o=1, PCWrite_o=1, next state FETCH.
  - Undecoded opcode: illegal_o=1, the instruction is treated as a NOP, next state FETCH.
  - All other opcodes: next state EXEC.
- EXEC: ALU_op_o from op_q. ALUSrc_o=1 for ADDI/ORI/LUI/LW/SW.
  - BEQ/BNE: Branch_o=1. PCWrite_o = zero_i (BEQ) or !zero_i (BNE). Next state FETCH.
  - LW/SW: next state MEM.
  - Else: next state WB.
- MEM: MemRead_o=1 (LW) or MemWrite_o=1 (SW). Hold until mem_ready_i=1, then go to WB (LW) or FETCH (SW).
- WB: RegWrite_o=1; RegDst_o=1 for R; MemtoReg_o=1 for LW. Next state FETCH.
- Watchdog: a wait counter of width $clog2(MEM_TIMEOUT+1) is cleared on entry to FETCH/MEM and whenever mem_ready_i=1. It increments each FETCH/MEM cycle with mem_ready_i=0. When it reaches MEM_TIMEOUT, the next state is HALT and timeout_o is set.
- HALT: all strobes 0, state held until reset. The counter saturates and never wraps.
- mem_ready_i is ignored outside FETCH/MEM.

## Timing
- Reset: on the edge with rst_i=1: state FETCH, op_q=0, counter=0, timeout_o=0. While rst_i=1, every output is forced to 0 (state_o=0).
- Reset mid-instruction aborts it at the next edge. No strobe is asserted in the reset cycle.
- Cycle counts with zero wait: J 2; BEQ/BNE 3; R/ADDI/ORI/LUI 4; SW 4; LW 5. Each wait cycle in FETCH/MEM adds 1.
- mem_ready_i=1 in the same cycle the counter reaches MEM_TIMEOUT: ready wins, no halt.
- illegal_o lasts exactly one cycle (the DECODE cycle).

## Configuration
- MULTICYCLE_CTRL_JAL_EN defined: opcode 0x03 (JAL) is decoded, path DECODE → WB.
  - In WB: RegWrite_o=1, savePC_o=1 (register file writes PC+4 into $31), and in the same cycle Jump_o=1, PCWrite_o=1.
  - JAL takes 3 cycles.
- Not defined: 0x03 is illegal (illegal_o pulse, NOP) and savePC_o is tied 0.

## Test plan
- Reset, then ADDI (0x08), mem_ready_i always 1 → state_o 0,1,2,4,0. In EXEC: ALU_op_o=000, ALUSrc_o=1. In WB: RegWrite_o=1, RegDst_o=0.
- LW with 2 wait cycles in MEM → MemRead_o high for 3 MEM cycles, then WB with MemtoReg_o=1 and RegWrite_o=1; 7 cycles total.
- BEQ with zero_i=1 → PCWrite_o=1 and Branch_o=1 in EXEC. BNE with zero_i=1 → PCWrite_o=0. Both return to FETCH after 3 cycles.
- Opcode 0x3F → illegal_o high for 1 cycle, no RegWrite_o or MemWrite_o, back to FETCH. Opcode 0x03 with the macro undefined gives the same result.
- mem_ready_i held 0 in FETCH for MEM_TIMEOUT=15 cycles → state_o=7 and timeout_o=1 held. Asserting rst_i for one edge returns to state 0 with timeout_o=0.
- With MULTICYCLE_CTRL_JAL_EN defined, JAL → in WB: savePC_o, RegWrite_o, Jump_o and PCWrite_o all 1; 3 cycles total.
